// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling on an oversample tick.
// Optional macro UART_RX_PARITY_EN: switches to 8E1 with even-parity checking
// (rx_perr); undefined gives 8N1 with rx_perr tied low.
module uart_rx #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxen,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_perr,
    output logic       rx_busy
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
    logic                   rxd_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Next-state logic: the line is only looked at on oversample ticks; strobes default low.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], rxd};
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (rxen) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        if (!rxd_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = 3'd0;
                        end else begin
                            // Start bit vanished before mid-bit: treat as a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shreg_d = {rxd_s, shreg_q[7:1]};
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        par_d   = rxd_s;
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rxd_s) begin
                            // Back to IDLE at mid-stop so a frame can follow with no gap.
                            data_d  = shreg_q;
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = (^shreg_q) ^ par_q;
`endif
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    // Wait for the line to return high; a held-low line is not a new start.
                    if (rxd_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            sync_q  <= '1;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;
    assign rx_busy  = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_perr  = perr_q;
`else
    assign rx_perr  = 1'b0;
`endif

endmodule
